// File: rtl/cpu_seq_ctrl.sv
// Multi-phase instruction sequencer. Owns the PC and the instruction register, runs the IMEM
// fetch handshake, strobes decode, gates register-file writes and resolves conditional branches.
module cpu_seq_ctrl #(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              IMEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_rdy,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            dec_en,
  input  logic            allow_wr,
  input  logic [12:0]     jmp_addr,
  input  logic            br_taken,
  output logic            rf_we,
  output logic            halted,
  output logic [1:0]      fault,
  output logic [2:0]      state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_ALU     = 7'b0110011;
  localparam logic [6:0] OP_ALU_I   = 7'b0010011;
  localparam logic [6:0] OP_COND_BR = 7'b1100011;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_MISALIGN = 2'b11;

  localparam int             CNT_W    = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  state_t            cur_state;
  state_t            state_next;
  logic [PC_W-1:0]   pc_next;
  logic [1:0]        fault_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic [6:0]        opcode;
  logic              is_alu;
  logic              is_br;
  logic              is_legal;
  logic [12:0]       jmp_even;
  logic [PC_W-1:0]   br_offset;
  logic [PC_W-1:0]   br_target;

  assign state     = cur_state;
  assign opcode    = instr[6:0];
  assign is_alu    = (opcode == OP_ALU) || (opcode == OP_ALU_I);
  assign is_br     = (opcode == OP_COND_BR);
  assign is_legal  = is_alu || is_br;

  // Branch offsets are halfword-granular: bit 0 is dropped before sign extension.
  assign jmp_even  = jmp_addr & 13'h1FFE;
  assign br_offset = {{(PC_W-13){jmp_even[12]}}, jmp_even};
  assign br_target = pc + br_offset;

  always_comb begin
    state_next = cur_state;
    pc_next    = pc;
    fault_next = fault;
    cnt_next   = cnt;
    case (cur_state)
      IDLE: begin
        if (run) state_next = FETCH;
      end
      FETCH: begin
        if (imem_rdy) begin
          state_next = DECODE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HALT;
          fault_next = FLT_TIMEOUT;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DECODE: begin
        if (is_legal) begin
          state_next = EXEC;
        end else begin
          state_next = HALT;
          fault_next = FLT_ILLEGAL;
        end
      end
      EXEC: state_next = WB;
      WB: begin
        if (is_br && br_taken && br_target[1]) begin
          state_next = HALT;
          fault_next = FLT_MISALIGN;
        end else begin
          pc_next    = (is_br && br_taken) ? br_target : pc + PC_W'(4);
          state_next = run ? FETCH : IDLE;
        end
      end
      HALT: state_next = HALT;
      default: begin
        // Unreachable encodings are treated as a corrupted opcode path.
        state_next = HALT;
        fault_next = FLT_ILLEGAL;
      end
    endcase
  end

  // Strobes are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      fault     <= FLT_NONE;
      cnt       <= '0;
      imem_req  <= 1'b0;
      dec_en    <= 1'b0;
      rf_we     <= 1'b0;
      halted    <= 1'b0;
    end else begin
      cur_state <= state_next;
      pc        <= pc_next;
      fault     <= fault_next;
      cnt       <= cnt_next;
      if (cur_state == FETCH && imem_rdy) instr <= imem_data;
      imem_req  <= (state_next == FETCH);
      dec_en    <= (state_next == DECODE);
      rf_we     <= (state_next == WB) && is_alu && allow_wr;
      halted    <= (state_next == HALT);
    end
  end
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: a directed vector table, hand-written corner sequences, and random
// instructions checked against an instruction-level reference model.
module tb_cpu_seq_ctrl;
  localparam logic [31:0] ALU  = 32'h00208033;
  localparam logic [31:0] ALUI = 32'h00100093;
  localparam logic [31:0] BR   = 32'h00000063;
  localparam logic [31:0] BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        rst, run, imem_req, imem_rdy, dec_en, allow_wr, br_taken, rf_we, halted;
  logic [31:0] imem_data, pc, instr;
  logic [12:0] jmp_addr;
  logic [1:0]  fault;
  logic [2:0]  state;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc, m_instr;

  typedef struct {
    logic [31:0] data;
    int          w;     // FETCH cycles without RDY before the acknowledge (>=15: never)
    bit          aw;
    bit          bt;
    logic [12:0] ja;
    int          drop;  // cycle index at which RUN is dropped, -1 for never
  } txn_t;

  typedef struct {
    txn_t        t;
    logic [31:0] pc;
    logic [1:0]  fault;
    int          we;
    int          cyc;
  } vec_t;

  typedef struct {
    int cyc;
    int nreq;
    int ndec;
    int nwe;
  } res_t;

  vec_t tbl [17];

  always #5 clk = ~clk;

  cpu_seq_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_rdy(imem_rdy),
    .imem_data(imem_data), .pc(pc), .instr(instr), .dec_en(dec_en), .allow_wr(allow_wr),
    .jmp_addr(jmp_addr), .br_taken(br_taken), .rf_we(rf_we), .halted(halted),
    .fault(fault), .state(state)
  );

  function automatic txn_t mk(logic [31:0] d, int w, bit aw, bit bt, logic [12:0] ja, int drop);
    txn_t t;
    t.data = d; t.w = w; t.aw = aw; t.bt = bt; t.ja = ja; t.drop = drop;
    return t;
  endfunction

  function automatic vec_t mkv(txn_t t, logic [31:0] p, logic [1:0] f, int we, int cyc);
    vec_t v;
    v.t = t; v.pc = p; v.fault = f; v.we = we; v.cyc = cyc;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: outcome of one instruction from its inputs and the current PC.
  task automatic model(input txn_t t, input logic [31:0] pc_in, output logic [31:0] epc,
                       output logic [1:0] ef, output int ewe, output int ecyc);
    logic [6:0]  op;
    longint      off;
    logic [31:0] tgt;
    op   = t.data[6:0];
    epc  = pc_in;
    ef   = 2'd0;
    ewe  = 0;
    ecyc = t.w + 4;
    if (t.w >= 15) begin
      ef = 2'd2; ecyc = 15;
    end else if (op != 7'h33 && op != 7'h13 && op != 7'h63) begin
      ef = 2'd1; ecyc = t.w + 2;
    end else if (op == 7'h63) begin
      if (t.bt) begin
        off = longint'(t.ja);
        if (off >= 4096) off = off - 8192;
        if (t.ja[0]) off = off - 1;
        tgt = 32'(longint'(pc_in) + off);
        if (tgt[1]) ef = 2'd3;
        else epc = tgt;
      end else begin
        epc = pc_in + 32'd4;
      end
    end else begin
      ewe = t.aw ? 1 : 0;
      epc = pc_in + 32'd4;
    end
  endtask

  // Acts as instruction memory for one instruction, starting with the DUT in FETCH.
  task automatic do_instr(input txn_t t, input bit noise, output res_t r);
    bit left;
    int i;
    left = 1'b0;
    r = '{default: 0};
    run = 1'b1;
    allow_wr = t.aw;
    br_taken = t.bt;
    jmp_addr = t.ja;
    for (i = 0; i < 40; i++) begin
      if (i > 0 && (halted || (left && (imem_req || state == 3'd0)))) break;
      r.nreq += int'(imem_req);
      r.ndec += int'(dec_en);
      r.nwe  += int'(rf_we);
      if (!imem_req) left = 1'b1;
      if (i == t.drop) run = 1'b0;
      if (i <= t.w) begin
        imem_rdy  = (i == t.w);
        imem_data = t.data;
      end else begin
        imem_rdy  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_data = noise ? $urandom : t.data;
      end
      tick();
    end
    imem_rdy = 1'b0;
    r.cyc = i;
  endtask

  task automatic check_txn(input string tag, input txn_t t, input logic [31:0] epc,
                           input logic [1:0] ef, input int ewe, input int ecyc, input res_t r);
    int          ereq, edec;
    logic [2:0]  est;
    logic [31:0] ei;
    ereq = (t.w >= 15) ? 15 : t.w + 1;
    edec = (ef == 2'd2) ? 0 : 1;
    est  = (ef != 2'd0) ? 3'd5 : ((t.drop >= 0) ? 3'd0 : 3'd1);
    ei   = (ef == 2'd2) ? m_instr : t.data;
    chk({tag, ".cycles"}, 64'(r.cyc), 64'(ecyc));
    chk({tag, ".pc"}, 64'(pc), 64'(epc));
    chk({tag, ".fault"}, 64'(fault), 64'(ef));
    chk({tag, ".state"}, 64'(state), 64'(est));
    chk({tag, ".halted"}, 64'(halted), 64'(ef != 2'd0));
    chk({tag, ".instr"}, 64'(instr), 64'(ei));
    chk({tag, ".req_cycles"}, 64'(r.nreq), 64'(ereq));
    chk({tag, ".dec_pulses"}, 64'(r.ndec), 64'(edec));
    chk({tag, ".we_pulses"}, 64'(r.nwe), 64'(ewe));
    $display("txn %s data=%08h w=%0d aw=%0d bt=%0d ja=%04h drop=%0d -> pc=%08h fault=%0d cyc=%0d we=%0d",
             tag, t.data, t.w, t.aw, t.bt, t.ja, t.drop, pc, fault, r.cyc, r.nwe);
    m_pc    = epc;
    m_instr = ei;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; imem_rdy = 1'b0; imem_data = '0;
    allow_wr = 1'b0; br_taken = 1'b0; jmp_addr = '0;
    tick();
    rst = 1'b0;
    tick();
    m_pc = 32'h0; m_instr = 32'h0;
    chk("reset.state", 64'(state), 64'd0);
    chk("reset.pc_instr", {pc, instr}, 64'd0);
    chk("reset.fault_strobes", 64'({fault, imem_req, dec_en, rf_we, halted}), 64'd0);
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    chk("start.req", 64'(imem_req), 64'd1);
    chk("start.state", 64'(state), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        r;
    txn_t        t;
    logic [31:0] epc, d;
    logic [1:0]  ef;
    int          ewe, ecyc;
    logic [6:0]  ops [3];

    ops = '{7'h33, 7'h13, 7'h63};

    tbl[0]  = mkv(mk(ALU,  0, 1, 0, 13'h0000, -1), 32'h0000_0004, 2'd0, 1, 4);
    tbl[1]  = mkv(mk(ALU,  0, 1, 0, 13'h0000, -1), 32'h0000_0008, 2'd0, 1, 4);
    tbl[2]  = mkv(mk(ALUI, 2, 0, 0, 13'h0000, -1), 32'h0000_000C, 2'd0, 0, 6);
    tbl[3]  = mkv(mk(ALU,  1, 1, 0, 13'h0000, -1), 32'h0000_0010, 2'd0, 1, 5);
    tbl[4]  = mkv(mk(BR,   0, 1, 0, 13'h0000, -1), 32'h0000_0014, 2'd0, 0, 4);
    tbl[5]  = mkv(mk(BR,   0, 1, 1, 13'h000C, -1), 32'h0000_0020, 2'd0, 0, 4);
    tbl[6]  = mkv(mk(BR,   0, 0, 1, 13'h1FF8, -1), 32'h0000_0018, 2'd0, 0, 4);
    tbl[7]  = mkv(mk(ALU,  0, 1, 0, 13'h0000, -1), 32'h0000_001C, 2'd0, 1, 4);
    tbl[8]  = mkv(mk(ALUI, 0, 1, 0, 13'h0000, -1), 32'h0000_0020, 2'd0, 1, 4);
    tbl[9]  = mkv(mk(BR,   0, 1, 0, 13'h1FF8, -1), 32'h0000_0024, 2'd0, 0, 4);
    tbl[10] = mkv(mk(BR,   0, 1, 1, 13'h0005, -1), 32'h0000_0028, 2'd0, 0, 4);
    tbl[11] = mkv(mk(ALU,  3, 1, 0, 13'h0000,  4), 32'h0000_002C, 2'd0, 1, 7);
    tbl[12] = mkv(mk(BR,  13, 1, 1, 13'h1FFD, -1), 32'h0000_0028, 2'd0, 0, 17);
    tbl[13] = mkv(mk(BR,   0, 1, 1, 13'h1FD8, -1), 32'h0000_0000, 2'd0, 0, 4);
    tbl[14] = mkv(mk(BR,   0, 1, 1, 13'h1FFC, -1), 32'hFFFF_FFFC, 2'd0, 0, 4);
    tbl[15] = mkv(mk(ALU,  0, 0, 0, 13'h0000, -1), 32'h0000_0000, 2'd0, 0, 4);
    tbl[16] = mkv(mk(BR,   0, 1, 1, 13'h0006, -1), 32'h0000_0000, 2'd3, 0, 4);

    rst = 1'b1; run = 1'b0; imem_rdy = 1'b0; imem_data = '0;
    allow_wr = 1'b0; br_taken = 1'b0; jmp_addr = '0;
    #2;
    chk("async_reset.state", 64'(state), 64'd0);
    do_reset();
    start();
    for (int k = 0; k < 17; k++) begin
      if (k > 0 && tbl[k-1].t.drop >= 0) start();
      do_instr(tbl[k].t, 1'b0, r);
      check_txn($sformatf("vec%0d", k), tbl[k].t, tbl[k].pc, tbl[k].fault, tbl[k].we, tbl[k].cyc, r);
    end

    // Fetch timeout: RDY never arrives.
    do_reset();
    start();
    t = mk(ALU, 99, 1, 0, 13'h0, -1);
    do_instr(t, 1'b0, r);
    check_txn("timeout", t, 32'h0, 2'd2, 0, 15, r);

    // Illegal opcode, then HALT must ignore all further activity.
    do_reset();
    start();
    t = mk(BAD, 1, 1, 0, 13'h0, -1);
    do_instr(t, 1'b0, r);
    check_txn("illegal", t, 32'h0, 2'd1, 0, 3, r);
    for (int k = 0; k < 8; k++) begin
      run = 1'($urandom_range(0, 1));
      imem_rdy = 1'($urandom_range(0, 1));
      imem_data = $urandom;
      tick();
      chk("halt_frozen.ctl", 64'({state, fault, imem_req, dec_en, rf_we, halted}),
          64'({3'd5, 2'd1, 4'b0001}));
      chk("halt_frozen.pc_instr", {pc, instr}, {32'h0, BAD});
    end
    do_reset();

    // Asynchronous reset while in EXEC.
    start();
    for (int k = 0; k < 2; k++) begin
      t = mk(ALU, 0, 1, 0, 13'h0, -1);
      do_instr(t, 1'b0, r);
      check_txn($sformatf("pre_rst%0d", k), t, m_pc + 32'd4, 2'd0, 1, 4, r);
    end
    imem_data = ALUI; imem_rdy = 1'b1; allow_wr = 1'b1;
    tick();
    imem_rdy = 1'b0;
    tick();
    chk("exec_before_rst.state", 64'(state), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.state", 64'(state), 64'd0);
    chk("mid_rst.pc_instr", {pc, instr}, 64'd0);
    chk("mid_rst.fault_strobes", 64'({fault, imem_req, dec_en, rf_we, halted}), 64'd0);
    $display("txn async_reset_in_exec -> state=%0d pc=%08h", state, pc);

    // Random instructions against the reference model.
    do_reset();
    start();
    for (int n = 0; n < 150; n++) begin
      int sel;
      sel = $urandom_range(0, 39);
      d = $urandom;
      if (sel > 3) d = (d & 32'hFFFF_FF80) | {25'b0, ops[$urandom_range(0, 2)]};
      t = mk(d, (sel == 3) ? 99 : $urandom_range(0, 13), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 13'($urandom), -1);
      if ($urandom_range(0, 5) == 0 && t.w < 15) t.drop = $urandom_range(0, t.w + 3);
      model(t, m_pc, epc, ef, ewe, ecyc);
      do_instr(t, 1'b1, r);
      check_txn($sformatf("rnd%0d", n), t, epc, ef, ewe, ecyc, r);
      if (ef != 2'd0) begin
        do_reset();
        start();
      end else if (t.drop >= 0) begin
        start();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
